sipo_word_collector: RTL

//  Serial-to-parallel receiver: the far end of a PISO shift chain (universal shift

---
 rtl/sipo_word_collector_pkg.sv | 15 +
 rtl/sipo_word_collector_shift_core.sv | 64 ++++++
 rtl/sipo_word_collector.sv | 110 +++++++++++
 3 files changed

// File: rtl/sipo_word_collector_pkg.sv
// Shared definitions for the serial word collector and its matching PISO transmitter:
// FSM state encoding and bit-counter sizing.
package sipo_word_collector_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sipo_state_e;

    // Counter must represent 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_word_collector_shift_core.sv
// Shift register plus bit counter for the serial collector. Exposes the word as it
// will look after this cycle's shift, together with a pulse when that shift completes it.
module sipo_shift_core
    import sipo_word_collector_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             shift_en,
    input  logic             restart,
    input  logic             ser_in,
    output logic [WIDTH-1:0] word,
    output logic             done
);

    localparam int                CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] sr_base;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // A restart throws away the partial word so stale bits never leak into the next one.
        sr_base = restart ? '0 : sr_q;
        if (MSB_FIRST) begin
            shifted = {sr_base[WIDTH-2:0], ser_in};
        end else begin
            shifted = {ser_in, sr_base[WIDTH-1:1]};
        end

        sr_d  = sr_q;
        cnt_d = cnt_q;
        done  = 1'b0;
        if (restart) begin
            sr_d  = shifted;
            cnt_d = CNT_W'(1);
        end else if (shift_en) begin
            sr_d = shifted;
            if (cnt_q == LAST) begin
                done  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign word = shifted;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sipo_word_collector.sv
// Serial-to-parallel word collector: framing FSM, one-entry holding register with
// valid/ready handoff, and sticky overrun / framing-error flags.
module sipo_word_collector
    import sipo_word_collector_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             SER_IN,
    input  logic             SER_VLD,
    input  logic             SER_START,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VLD,
    input  logic             OUT_RDY,
    output logic             OVERRUN,
    output logic             FRAME_ERR,
    input  logic             CLR_ERR
);

    sipo_state_e      state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_vld_q, out_vld_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic             restart;
    logic             shift_en;
    logic             done;
    logic [WIDTH-1:0] word;
    logic             frame_set;
    logic             load;
    logic             drop;

    // A start bit always begins a fresh word; plain bits only count while framed.
    assign restart  = SER_VLD & SER_START;
    assign shift_en = SER_VLD & ~SER_START & (state_q == ST_SHIFT);

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk      (CLK),
        .clr_n    (CLR_N),
        .shift_en (shift_en),
        .restart  (restart),
        .ser_in   (SER_IN),
        .word     (word),
        .done     (done)
    );

    always_comb begin
        state_d   = state_q;
        frame_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (restart) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (restart) begin
                    frame_set = 1'b1;
                end else if (done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The holding slot accepts a finished word if empty or being emptied this cycle.
    always_comb begin
        load       = done & (~out_vld_q | OUT_RDY);
        drop       = done & out_vld_q & ~OUT_RDY;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        if (load) begin
            out_data_d = word;
            out_vld_d  = 1'b1;
        end else if (out_vld_q && OUT_RDY) begin
            out_vld_d = 1'b0;
        end
        overrun_d   = drop      | (overrun_q   & ~CLR_ERR);
        frame_err_d = frame_set | (frame_err_q & ~CLR_ERR);
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q     <= ST_IDLE;
            out_data_q  <= '0;
            out_vld_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_vld_q   <= out_vld_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_VLD   = out_vld_q;
    assign OVERRUN   = overrun_q;
    assign FRAME_ERR = frame_err_q;

endmodule
